// File: rtl/bnn_seq_core.sv
// -----------------------------------------------------------------------------
// bnn_seq_core
// Clock-serial two-layer binarised classifier with valid/ready streaming.
// A feature vector is binarised and latched when it is accepted. The core then
// evaluates PAR hidden neurons per cycle and one output class per cycle while
// keeping a running argmax. Ties go to the lowest class index.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   in_valid   in   feature vector valid
//   in_ready   out  core idle and able to accept a feature vector
//   features   in   FEAT_CNT unsigned features, feature f at [f*FEAT_BITS +: FEAT_BITS]
//   out_valid  out  prediction/score valid; held until out_ready
//   out_ready  in   consumer accepts the result
//   prediction out  winning class index
//   score      out  popcount of the winning class
// -----------------------------------------------------------------------------
module bnn_seq_core #(
   parameter int FEAT_CNT    = 128,
   parameter int FEAT_BITS   = 4,
   parameter int HIDDEN_CNT  = 40,
   parameter int CLASS_CNT   = 6,
   parameter int PAR         = 1,
   parameter int FEAT_THRESH = 2**(FEAT_BITS-1),
   parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '0,
   parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [FEAT_BITS*FEAT_CNT-1:0]     features,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(CLASS_CNT)-1:0]      prediction,
   output logic [$clog2(HIDDEN_CNT+1)-1:0]   score
);

   localparam int SW  = $clog2(HIDDEN_CNT+1);
   localparam int PW  = $clog2(CLASS_CNT);
   localparam int FPW = $clog2(FEAT_CNT+1);
   localparam int HIW = $clog2(HIDDEN_CNT+PAR+1);
   localparam int CIW = $clog2(CLASS_CNT+1);
   // Majority threshold: ceil(FEAT_CNT/2) agreeing bits fire a hidden neuron.
   localparam logic [FPW-1:0]     MAJ = FPW'((FEAT_CNT+1)/2);
   // One extra bit so a threshold of 2**FEAT_BITS is representable.
   localparam logic [FEAT_BITS:0] THR = (FEAT_BITS+1)'(FEAT_THRESH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HIDDEN = 2'd1,
      CLASS  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Number of agreeing bits between a binarised feature vector and a weight row.
   function automatic logic [FPW-1:0] pop_feat(input logic [FEAT_CNT-1:0] v);
      logic [FPW-1:0] cnt;
      cnt = {FPW{1'b0}};
      for (int i = 0; i < FEAT_CNT; i++) begin
         cnt = cnt + FPW'(v[i]);
      end
      return cnt;
   endfunction

   // Number of agreeing bits between the hidden vector and a class weight row.
   function automatic logic [SW-1:0] pop_hid(input logic [HIDDEN_CNT-1:0] v);
      logic [SW-1:0] cnt;
      cnt = {SW{1'b0}};
      for (int i = 0; i < HIDDEN_CNT; i++) begin
         cnt = cnt + SW'(v[i]);
      end
      return cnt;
   endfunction

   state_t                  state_r;
   logic [FEAT_CNT-1:0]     fb_s;
   logic [FEAT_CNT-1:0]     fb_r;
   logic [HIDDEN_CNT-1:0]   hidden_r;
   logic [HIDDEN_CNT-1:0]   hidden_nxt_s;
   int                      lane_row_s [PAR];
   logic [PAR-1:0]          lane_bit_s;
   logic [HIW-1:0]          hid_idx_r;
   logic                    hid_last_s;
   logic [CIW-1:0]          cls_idx_r;
   logic                    cls_issue_s;
   int                      cls_row_s;
   logic [SW-1:0]           cls_score_s;
   logic [SW-1:0]           pipe_score_r;
   logic [PW-1:0]           pipe_idx_r;
   logic                    pipe_vld_r;
   logic [SW-1:0]           best_score_r;
   logic [PW-1:0]           best_idx_r;
   logic                    take_s;
   logic [SW-1:0]           next_score_s;
   logic [PW-1:0]           next_idx_s;
   logic                    in_ready_r;
   logic                    out_valid_r;
   logic [PW-1:0]           prediction_r;
   logic [SW-1:0]           score_r;

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign prediction = prediction_r;
   assign score      = score_r;

   // Binarise the incoming features; only latched on the accept edge.
   always_comb begin
      fb_s = {FEAT_CNT{1'b0}};
      for (int f = 0; f < FEAT_CNT; f++) begin
         fb_s[f] = ({1'b0, features[f*FEAT_BITS +: FEAT_BITS]} >= THR);
      end
   end

   // Weight row for each hidden lane; out-of-range lanes read row 0 and are
   // discarded when the hidden register is written.
   always_comb begin
      for (int p = 0; p < PAR; p++) begin
         lane_row_s[p] = ((int'(hid_idx_r) + p) < HIDDEN_CNT) ? (int'(hid_idx_r) + p) : 0;
      end
   end

   // PAR parallel hidden neurons: majority of XNOR agreement.
   always_comb begin
      lane_bit_s = {PAR{1'b0}};
      for (int p = 0; p < PAR; p++) begin
         lane_bit_s[p] = (pop_feat(~(fb_r ^ W1[lane_row_s[p]*FEAT_CNT +: FEAT_CNT])) >= MAJ);
      end
   end

   // Merge lane results into the hidden vector; lanes past HIDDEN_CNT match no neuron.
   always_comb begin
      hidden_nxt_s = hidden_r;
      for (int h = 0; h < HIDDEN_CNT; h++) begin
         for (int p = 0; p < PAR; p++) begin
            if ((int'(hid_idx_r) + p) == h) begin
               hidden_nxt_s[h] = lane_bit_s[p];
            end else begin
               hidden_nxt_s[h] = hidden_nxt_s[h];
            end
         end
      end
      hid_last_s = ((int'(hid_idx_r) + PAR) >= HIDDEN_CNT);
   end

   // Class score for the class being issued this cycle.
   always_comb begin
      cls_issue_s = (int'(cls_idx_r) < CLASS_CNT);
      cls_row_s   = cls_issue_s ? int'(cls_idx_r) : 0;
      cls_score_s = pop_hid(~(hidden_r ^ W2[cls_row_s*HIDDEN_CNT +: HIDDEN_CNT]));
   end

   // Running argmax: the class score is registered first, then compared against
   // best one cycle later. Class 0 always loads; later classes need strictly greater.
   always_comb begin
      take_s = pipe_vld_r && ((pipe_idx_r == {PW{1'b0}}) || (pipe_score_r > best_score_r));
      if (take_s) begin
         next_score_s = pipe_score_r;
         next_idx_s   = pipe_idx_r;
      end else begin
         next_score_s = best_score_r;
         next_idx_s   = best_idx_r;
      end
   end

   // Control FSM with all datapath registers and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= IDLE;
         fb_r         <= {FEAT_CNT{1'b0}};
         hidden_r     <= {HIDDEN_CNT{1'b0}};
         hid_idx_r    <= {HIW{1'b0}};
         cls_idx_r    <= {CIW{1'b0}};
         pipe_score_r <= {SW{1'b0}};
         pipe_idx_r   <= {PW{1'b0}};
         pipe_vld_r   <= 1'b0;
         best_score_r <= {SW{1'b0}};
         best_idx_r   <= {PW{1'b0}};
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         prediction_r <= {PW{1'b0}};
         score_r      <= {SW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  fb_r         <= fb_s;
                  hid_idx_r    <= {HIW{1'b0}};
                  best_score_r <= {SW{1'b0}};
                  best_idx_r   <= {PW{1'b0}};
                  pipe_vld_r   <= 1'b0;
                  in_ready_r   <= 1'b0;
                  state_r      <= HIDDEN;
               end else begin
                  in_ready_r   <= 1'b1;
               end
            end
            HIDDEN: begin
               hidden_r  <= hidden_nxt_s;
               hid_idx_r <= hid_idx_r + HIW'(PAR);
               if (hid_last_s) begin
                  cls_idx_r  <= {CIW{1'b0}};
                  pipe_vld_r <= 1'b0;
                  state_r    <= CLASS;
               end else begin
                  state_r    <= HIDDEN;
               end
            end
            CLASS: begin
               if (cls_issue_s) begin
                  pipe_score_r <= cls_score_s;
                  pipe_idx_r   <= PW'(cls_idx_r);
                  pipe_vld_r   <= 1'b1;
                  cls_idx_r    <= cls_idx_r + CIW'(1);
               end else begin
                  pipe_vld_r   <= 1'b0;
               end
               best_score_r <= next_score_s;
               best_idx_r   <= next_idx_s;
               // The pipe holds the last class once nothing is left to issue.
               if (!cls_issue_s) begin
                  prediction_r <= next_idx_s;
                  score_r      <= next_score_s;
                  out_valid_r  <= 1'b1;
                  state_r      <= DONE;
               end else begin
                  state_r      <= CLASS;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_seq_core.sv
// -----------------------------------------------------------------------------
// tb_bnn_seq_core
// Self-checking bench. DUT A uses the small configuration (8/4/5/3, PAR=2,
// NH=3, latency 7). DUT B uses the default sizes (128/40/6, PAR=1, latency 47).
// Expected results come from an argmax reference model that works on plain
// integer arrays.
// -----------------------------------------------------------------------------
module tb_bnn_seq_core;

   localparam int A_FC = 8, A_FB = 4, A_HC = 5, A_CC = 3, A_PAR = 2;
   localparam int A_LAT = 7;
   localparam logic [39:0] A_W1 = 40'hA5C3961EF0;
   localparam logic [14:0] A_W2 = 15'h5A93;

   localparam int B_FC = 128, B_FB = 4, B_HC = 40, B_CC = 6;
   localparam int B_LAT = 47;
   localparam logic [5149:0] B_W1_RAW = {103{50'h2D3A59C617B0E}};
   localparam logic [5119:0] B_W1     = B_W1_RAW[5119:0];
   localparam logic [258:0]  B_W2_RAW = {7{37'h1B9E36B5A7}};
   localparam logic [239:0]  B_W2     = B_W2_RAW[239:0];

   logic         clk = 1'b0;
   logic         rst;
   logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0]  a_features;
   logic [1:0]   a_prediction;
   logic [2:0]   a_score;
   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [511:0] b_features;
   logic [2:0]   b_prediction;
   logic [5:0]   b_score;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   bnn_seq_core #(.FEAT_CNT(A_FC), .FEAT_BITS(A_FB), .HIDDEN_CNT(A_HC), .CLASS_CNT(A_CC),
                  .PAR(A_PAR), .W1(A_W1), .W2(A_W2)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .features(a_features), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .prediction(a_prediction), .score(a_score));

   bnn_seq_core #(.FEAT_CNT(B_FC), .FEAT_BITS(B_FB), .HIDDEN_CNT(B_HC), .CLASS_CNT(B_CC),
                  .PAR(1), .W1(B_W1), .W2(B_W2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .features(b_features), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .prediction(b_prediction), .score(b_score));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference classifier: binarise, majority hidden layer, argmax with lowest-index ties.
   function automatic void model(input logic [511:0] feats, input int fc, input int fbits,
                                 input int hc, input int cc, input logic [5119:0] w1,
                                 input logic [239:0] w2, output int pred, output int sc);
      bit fb [512];
      bit hid [64];
      int fv, agree, s;
      pred = 0;
      sc   = -1;
      for (int f = 0; f < fc; f++) begin
         fv = 0;
         for (int b = 0; b < fbits; b++) if (feats[f*fbits+b]) fv += (1 << b);
         fb[f] = (fv >= (1 << (fbits-1)));
      end
      for (int h = 0; h < hc; h++) begin
         agree = 0;
         for (int f = 0; f < fc; f++) if (fb[f] == w1[h*fc+f]) agree++;
         hid[h] = (2*agree >= fc);
      end
      for (int c = 0; c < cc; c++) begin
         s = 0;
         for (int h = 0; h < hc; h++) if (hid[h] == w2[c*hc+h]) s++;
         if (s > sc) begin
            sc   = s;
            pred = c;
         end
      end
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_features = 32'h0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_features = 512'h0;
      repeat (3) @(negedge clk);
      n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_in_ready got %b want 1", a_in_ready); end
      n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_out_valid got %b want 0", a_out_valid); end
      n_cmp++; if (a_prediction !== 2'd0 || a_score !== 3'd0) begin n_bad++; $display("FAIL reset_a_outputs got %0d/%0d want 0/0", a_prediction, a_score); end
      n_cmp++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_handshake got %b/%b want 1/0", b_in_ready, b_out_valid); end
      n_cmp++; if (b_prediction !== 3'd0 || b_score !== 6'd0) begin n_bad++; $display("FAIL reset_b_outputs got %0d/%0d want 0/0", b_prediction, b_score); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   // One complete transaction on DUT A, called at a negedge.
   task automatic run_a(input logic [31:0] f, input string tag);
      int ep, es, lat, k;
      model(512'(f), A_FC, A_FB, A_HC, A_CC, 5120'(A_W1), 240'(A_W2), ep, es);
      k = 0;
      while (!a_in_ready && k < 100) begin @(negedge clk); k++; end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL %s in_ready_timeout got %b want 1", tag, a_in_ready); end
      a_features = f; a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      lat = 0;
      while (!a_out_valid && lat < 200) begin @(negedge clk); lat++; end
      n_cmp++; if (lat != A_LAT) begin n_bad++; $display("FAIL %s latency got %0d want %0d", tag, lat, A_LAT); end
      n_cmp++; if (a_prediction !== ep[1:0]) begin n_bad++; $display("FAIL %s prediction got %0d want %0d", tag, a_prediction, ep); end
      n_cmp++; if (a_score !== es[2:0]) begin n_bad++; $display("FAIL %s score got %0d want %0d", tag, a_score, es); end
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL %s post_accept got ov=%b ir=%b want 0/1", tag, a_out_valid, a_in_ready); end
      n_cmp++; if (a_prediction !== ep[1:0] || a_score !== es[2:0]) begin n_bad++; $display("FAIL %s hold got %0d/%0d want %0d/%0d", tag, a_prediction, a_score, ep, es); end
   endtask

   task automatic test_directed();
      run_a(32'h00000000, "zero_feat");
      run_a(32'hFFFFFFFF, "max_feat");
      run_a(32'h88888888, "at_thresh");
      run_a(32'h77777777, "below_thresh");
      run_a(32'hF0F0F0F0, "alt_feat");
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) run_a($urandom, "random_a");
   endtask

   task automatic test_backpressure();
      int ep, es, ep1, es1, lat;
      logic [31:0] f0, f1;
      f0 = $urandom;
      model(512'(f0), A_FC, A_FB, A_HC, A_CC, 5120'(A_W1), 240'(A_W2), ep, es);
      a_features = f0; a_in_valid = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!a_out_valid && lat < 200) begin
         a_features = $urandom;
         @(negedge clk); lat++;
      end
      n_cmp++; if (lat != A_LAT) begin n_bad++; $display("FAIL bp_latency got %0d want %0d", lat, A_LAT); end
      for (int i = 0; i < 10; i++) begin
         a_features = $urandom;
         @(negedge clk);
         n_cmp++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall_hs got ov=%b ir=%b want 1/0", a_out_valid, a_in_ready); end
         n_cmp++; if (a_prediction !== ep[1:0] || a_score !== es[2:0]) begin n_bad++; $display("FAIL bp_stall_data got %0d/%0d want %0d/%0d", a_prediction, a_score, ep, es); end
      end
      f1 = $urandom;
      model(512'(f1), A_FC, A_FB, A_HC, A_CC, 5120'(A_W1), 240'(A_W2), ep1, es1);
      a_features = f1; a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got ov=%b ir=%b want 0/1", a_out_valid, a_in_ready); end
      @(negedge clk);
      a_in_valid = 1'b0;
      n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_reaccept got ir=%b want 0", a_in_ready); end
      lat = 0;
      while (!a_out_valid && lat < 200) begin @(negedge clk); lat++; end
      n_cmp++; if (lat != A_LAT) begin n_bad++; $display("FAIL bp_next_latency got %0d want %0d", lat, A_LAT); end
      n_cmp++; if (a_prediction !== ep1[1:0] || a_score !== es1[2:0]) begin n_bad++; $display("FAIL bp_next_data got %0d/%0d want %0d/%0d", a_prediction, a_score, ep1, es1); end
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int seen;
      a_features = $urandom; a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_hs got ir=%b ov=%b want 1/0", a_in_ready, a_out_valid); end
      n_cmp++; if (a_prediction !== 2'd0 || a_score !== 3'd0) begin n_bad++; $display("FAIL midrst_outputs got %0d/%0d want 0/0", a_prediction, a_score); end
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (a_out_valid) seen++;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_no_result got %0d valid cycles want 0", seen); end
      run_a($urandom, "after_reset");
   endtask

   task automatic test_back_to_back();
      int exp_p_q [$];
      int exp_s_q [$];
      int acc_q [$];
      int ep, es, p, s, a;
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      for (int i = 0; i < 90; i++) begin
         if (i < 70) a_features = $urandom;
         else a_in_valid = 1'b0;
         if (a_in_valid && a_in_ready) begin
            model(512'(a_features), A_FC, A_FB, A_HC, A_CC, 5120'(A_W1), 240'(A_W2), ep, es);
            exp_p_q.push_back(ep); exp_s_q.push_back(es); acc_q.push_back(cyc + 1);
         end
         @(negedge clk);
         if (a_out_valid) begin
            n_cmp++;
            if (acc_q.size() == 0) begin
               n_bad++; $display("FAIL b2b_unexpected got out_valid=1 want 0");
            end else begin
               p = exp_p_q.pop_front(); s = exp_s_q.pop_front(); a = acc_q.pop_front();
               if (a_prediction !== p[1:0] || a_score !== s[2:0]) begin n_bad++; $display("FAIL b2b_data got %0d/%0d want %0d/%0d", a_prediction, a_score, p, s); end
               n_cmp++; if (cyc - a != A_LAT) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", cyc - a, A_LAT); end
            end
         end
      end
      n_cmp++; if (acc_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain got %0d pending want 0", acc_q.size()); end
      a_out_ready = 1'b0;
   endtask

   task automatic test_defaults();
      int ep, es, lat, k;
      logic [511:0] f;
      for (int v = 0; v < 150; v++) begin
         for (int w = 0; w < 16; w++) f[w*32 +: 32] = $urandom;
         model(f, B_FC, B_FB, B_HC, B_CC, B_W1, B_W2, ep, es);
         k = 0;
         while (!b_in_ready && k < 100) begin @(negedge clk); k++; end
         b_features = f; b_in_valid = 1'b1;
         @(negedge clk);
         b_in_valid = 1'b0;
         lat = 0;
         while (!b_out_valid && lat < 200) begin @(negedge clk); lat++; end
         n_cmp++; if (lat != B_LAT) begin n_bad++; $display("FAIL dflt_latency vec %0d got %0d want %0d", v, lat, B_LAT); end
         n_cmp++; if (b_prediction !== ep[2:0]) begin n_bad++; $display("FAIL dflt_prediction vec %0d got %0d want %0d", v, b_prediction, ep); end
         n_cmp++; if (b_score !== es[5:0]) begin n_bad++; $display("FAIL dflt_score vec %0d got %0d want %0d", v, b_score, es); end
         b_out_ready = 1'b1;
         @(negedge clk);
         b_out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_defaults();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
